sram_access_ctrl: RTL and testbench

- Memory-side stage downstream of the SLC-3 control unit. Consumes the Mem_OE/Mem_WE strobes plus the MAR/MDR contents.
- Sequences the external async SRAM with parameterised wait states and returns read data and a completion pulse to the datapath MDR.
- Decodes one memory-mapped I/O address: reads return the switches, writes load the hex/LED register.

---
 rtl/sram_access_ctrl_if.sv | 37 +++
 rtl/sram_access_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Bus bundle between the SLC-3 datapath/control unit, the external async SRAM
// and the board I/O, as seen by the SRAM access controller.
interface sram_access_ctrl_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] MAR;
    logic [15:0] MDR_out;
    logic [15:0] Switches;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] Data_to_CPU;
    logic        Data_valid;
    logic        Done;
    logic        Busy;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] IO_out;

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR_out, Switches, SRAM_DQ_in,
        input  Data_to_CPU, Data_valid, Done, Busy, SRAM_ADDR,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
               SRAM_DQ_out, SRAM_DQ_oe, IO_out
    );

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR_out, Switches, SRAM_DQ_in,
        output Data_to_CPU, Data_valid, Done, Busy, SRAM_ADDR,
               SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
               SRAM_DQ_out, SRAM_DQ_oe, IO_out
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences one async SRAM (or memory-mapped I/O) access per control-unit
// request, with parameterised read/write wait states and registered strobes.
module sram_access_ctrl #(
    parameter int          RD_WAIT = 2,
    parameter int          WR_WAIT = 2,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input logic Clk,
    input logic Reset,
    sram_access_ctrl_if.slave bus
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE,
        RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [15:0]   addr_q;
    logic [15:0]   data_q;
    logic [15:0]   data_to_cpu;
    logic [15:0]   io_reg;
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic          byte_n;
    logic          dq_oe;
    logic          data_valid;
    logic          done;

    // Strobes are registered so they change only on clock edges (or reset),
    // which keeps WE_N glitch-free at the SRAM pins.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            data_to_cpu <= '0;
            io_reg      <= '0;
            ce_n        <= 1'b1;
            oe_n        <= 1'b1;
            we_n        <= 1'b1;
            byte_n      <= 1'b1;
            dq_oe       <= 1'b0;
            data_valid  <= 1'b0;
            done        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Mem_WE || bus.Mem_OE) begin
                        addr_q <= bus.MAR;
                        data_q <= bus.MDR_out;
                    end
                    // Write wins when both request levels are high.
                    if (bus.Mem_WE) begin
                        if (bus.MAR == IO_ADDR) begin
                            io_reg <= bus.MDR_out;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            ce_n   <= 1'b0;
                            byte_n <= 1'b0;
                            dq_oe  <= 1'b1;
                            state  <= WR_SETUP;
                        end
                    end else if (bus.Mem_OE) begin
                        if (bus.MAR == IO_ADDR) begin
                            data_to_cpu <= bus.Switches;
                            data_valid  <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            ce_n   <= 1'b0;
                            oe_n   <= 1'b0;
                            byte_n <= 1'b0;
                            cnt    <= CW'(RD_WAIT - 1);
                            state  <= RD;
                        end
                    end
                end
                RD: begin
                    if (cnt == '0) begin
                        data_to_cpu <= bus.SRAM_DQ_in;
                        data_valid  <= 1'b1;
                        done        <= 1'b1;
                        ce_n        <= 1'b1;
                        oe_n        <= 1'b1;
                        byte_n      <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR_SETUP: begin
                    we_n  <= 1'b0;
                    cnt   <= CW'(WR_WAIT - 1);
                    state <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt == '0) begin
                        we_n  <= 1'b1;
                        state <= WR_HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WR_HOLD: begin
                    ce_n   <= 1'b1;
                    byte_n <= 1'b1;
                    dq_oe  <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // Held request levels must drop before another access is taken.
                    if (!bus.Mem_OE && !bus.Mem_WE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Data_to_CPU = data_to_cpu;
    assign bus.Data_valid  = data_valid;
    assign bus.Done        = done;
    assign bus.Busy        = (state != IDLE);
    assign bus.SRAM_ADDR   = {4'b0000, addr_q};
    assign bus.SRAM_CE_N   = ce_n;
    assign bus.SRAM_OE_N   = oe_n;
    assign bus.SRAM_WE_N   = we_n;
    assign bus.SRAM_UB_N   = byte_n;
    assign bus.SRAM_LB_N   = byte_n;
    assign bus.SRAM_DQ_out = data_q;
    assign bus.SRAM_DQ_oe  = dq_oe;
    assign bus.IO_out      = io_reg;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl: async SRAM device model plus a
// transaction-level reference (latencies, strobe counts, memory contents).
module tb_sram_access_ctrl;

    localparam int          RD_WAIT = 2;
    localparam int          WR_WAIT = 2;
    localparam logic [15:0] IO_ADDR = 16'hFFFF;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    sram_access_ctrl_if bus ();

    sram_access_ctrl #(
        .RD_WAIT (RD_WAIT),
        .WR_WAIT (WR_WAIT),
        .IO_ADDR (IO_ADDR)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int          done_cyc;
        int          idle_cyc;
        int          oe_cnt;
        int          we_cnt;
        int          ce_cnt;
        int          setup_cnt;
        int          hold_cnt;
        int          done_cnt;
        int          dv_cnt;
        logic [15:0] dout;
        bit          bus_bad;
        bit          timeout;
    } result_t;

    // Power-up contents of the SRAM; address 0x0042 holds a known marker.
    function automatic logic [15:0] init_pat(input logic [15:0] a);
        return (a == 16'h0042) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    // Async SRAM device: reads while CE_N/OE_N low, commits on WE_N rising.
    logic [15:0] sram_wr [logic [15:0]];

    always_comb begin
        bus.SRAM_DQ_in = 16'hDEAD;
        if (!bus.SRAM_CE_N && !bus.SRAM_OE_N) begin
            if (sram_wr.exists(bus.SRAM_ADDR[15:0]))
                bus.SRAM_DQ_in = sram_wr[bus.SRAM_ADDR[15:0]];
            else
                bus.SRAM_DQ_in = init_pat(bus.SRAM_ADDR[15:0]);
        end
    end

    always @(posedge bus.SRAM_WE_N) begin
        if (!Reset && !bus.SRAM_CE_N && bus.SRAM_DQ_oe)
            sram_wr[bus.SRAM_ADDR[15:0]] = bus.SRAM_DQ_out;
    end

    // Reference model state
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] last_read;
    logic [15:0] io_model;

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_pat(a);
    endfunction

    function automatic int exp_done(input bit wr, input bit rd, input logic [15:0] a);
        if (a == IO_ADDR) return 1;
        if (wr) return WR_WAIT + 3;
        if (rd) return RD_WAIT + 1;
        return 0;
    endfunction

    // Issue one request at the next edge, hold it for 'hold' cycles, observe every cycle.
    task automatic run_access(input bit wr, input bit rd, input logic [15:0] addr,
                              input logic [15:0] wdata, input int hold, output result_t r);
        bit we_seen;
        we_seen = 1'b0;
        r = '{done_cyc: -1, idle_cyc: -1, oe_cnt: 0, we_cnt: 0, ce_cnt: 0, setup_cnt: 0,
              hold_cnt: 0, done_cnt: 0, dv_cnt: 0, dout: 16'h0, bus_bad: 1'b0, timeout: 1'b0};
        @(negedge Clk);
        bus.MAR     = addr;
        bus.MDR_out = wdata;
        bus.Mem_WE  = wr;
        bus.Mem_OE  = rd;
        for (int k = 1; k <= 200; k++) begin
            @(negedge Clk);
            if (!bus.SRAM_OE_N) r.oe_cnt++;
            if (!bus.SRAM_WE_N) begin r.we_cnt++; we_seen = 1'b1; end
            if (!bus.SRAM_CE_N) r.ce_cnt++;
            if (!bus.SRAM_CE_N && bus.SRAM_WE_N && bus.SRAM_DQ_oe) begin
                if (we_seen) r.hold_cnt++;
                else         r.setup_cnt++;
            end
            if (bus.Done) begin
                r.done_cnt++;
                if (r.done_cyc < 0) r.done_cyc = k;
                r.dout = bus.Data_to_CPU;
            end
            if (bus.Data_valid) r.dv_cnt++;
            if (bus.Data_valid && !bus.Done) r.bus_bad = 1'b1;
            if (bus.SRAM_DQ_oe && !bus.SRAM_OE_N) r.bus_bad = 1'b1;
            if (bus.SRAM_DQ_oe && bus.SRAM_DQ_out !== wdata) r.bus_bad = 1'b1;
            if (!bus.SRAM_CE_N && bus.SRAM_ADDR !== {4'h0, addr}) r.bus_bad = 1'b1;
            if (k > hold && !bus.Busy) begin
                r.idle_cyc = k;
                break;
            end
            if (k == 1) begin
                bus.MAR     = 16'($urandom);
                bus.MDR_out = 16'($urandom);
            end
            if (k == hold) begin
                bus.Mem_OE = 1'b0;
                bus.Mem_WE = 1'b0;
            end
        end
        bus.Mem_OE = 1'b0;
        bus.Mem_WE = 1'b0;
        if (r.idle_cyc < 0) r.timeout = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #3;
        n_checks++;
        if ({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N} !== 5'b11111) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got %b expected 11111",
                     {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N});
        end
        n_checks++;
        if ({bus.SRAM_DQ_oe, bus.Busy, bus.Done, bus.Data_valid} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b expected 0000",
                     {bus.SRAM_DQ_oe, bus.Busy, bus.Done, bus.Data_valid});
        end
        n_checks++;
        if (bus.Data_to_CPU !== 16'h0 || bus.IO_out !== 16'h0 || bus.SRAM_ADDR !== 20'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: got data=%h io=%h addr=%h expected all zero",
                     bus.Data_to_CPU, bus.IO_out, bus.SRAM_ADDR);
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_sram_read();
        result_t r;
        run_access(1'b0, 1'b1, 16'h0042, 16'h0, RD_WAIT + 1, r);
        n_checks++;
        if (r.oe_cnt !== RD_WAIT) begin
            n_fail++; $display("[TB] FAIL rd_oe_cycles: got %0d expected %0d", r.oe_cnt, RD_WAIT);
        end
        n_checks++;
        if (r.done_cyc !== RD_WAIT + 1 || r.dv_cnt !== 1 || r.done_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL rd_latency: got done@%0d dv=%0d done=%0d expected done@%0d dv=1 done=1",
                     r.done_cyc, r.dv_cnt, r.done_cnt, RD_WAIT + 1);
        end
        n_checks++;
        if (r.dout !== 16'hBEEF) begin
            n_fail++; $display("[TB] FAIL rd_data: got %h expected BEEF", r.dout);
        end
        n_checks++;
        if (bus.SRAM_ADDR !== 20'h00042 || r.bus_bad) begin
            n_fail++; $display("[TB] FAIL rd_addr: got %h bus_bad=%0d expected 00042 bus_bad=0",
                               bus.SRAM_ADDR, r.bus_bad);
        end
        n_checks++;
        if (r.timeout || r.idle_cyc !== RD_WAIT + 3) begin
            n_fail++; $display("[TB] FAIL rd_release: got idle@%0d expected idle@%0d", r.idle_cyc, RD_WAIT + 3);
        end
        last_read = 16'hBEEF;
    endtask

    task automatic test_sram_write();
        result_t r;
        run_access(1'b1, 1'b0, 16'h0010, 16'h1234, 1, r);
        ref_mem[16'h0010] = 16'h1234;
        n_checks++;
        if (r.setup_cnt !== 1 || r.we_cnt !== WR_WAIT || r.hold_cnt !== 1) begin
            n_fail++;
            $display("[TB] FAIL wr_sequence: got setup=%0d we=%0d hold=%0d expected 1/%0d/1",
                     r.setup_cnt, r.we_cnt, r.hold_cnt, WR_WAIT);
        end
        n_checks++;
        if (r.oe_cnt !== 0 || r.bus_bad || r.dv_cnt !== 0) begin
            n_fail++; $display("[TB] FAIL wr_bus: got oe=%0d bus_bad=%0d dv=%0d expected 0/0/0",
                               r.oe_cnt, r.bus_bad, r.dv_cnt);
        end
        n_checks++;
        if (r.done_cyc !== WR_WAIT + 3 || r.done_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL wr_done: got done@%0d x%0d expected done@%0d x1",
                               r.done_cyc, r.done_cnt, WR_WAIT + 3);
        end
        n_checks++;
        if (bus.Data_to_CPU !== last_read) begin
            n_fail++; $display("[TB] FAIL wr_keeps_data: got %h expected %h", bus.Data_to_CPU, last_read);
        end
        run_access(1'b0, 1'b1, 16'h0010, 16'h0, 1, r);
        n_checks++;
        if (r.dout !== 16'h1234 || r.dv_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL wr_readback: got %h dv=%0d expected 1234 dv=1", r.dout, r.dv_cnt);
        end
        last_read = 16'h1234;
    endtask

    task automatic test_io();
        result_t r;
        bus.Switches = 16'h00A5;
        run_access(1'b0, 1'b1, IO_ADDR, 16'h0, 1, r);
        n_checks++;
        if (r.done_cyc !== 1 || r.dout !== 16'h00A5 || r.dv_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL io_read: got done@%0d data=%h dv=%0d expected done@1 data=00A5 dv=1",
                               r.done_cyc, r.dout, r.dv_cnt);
        end
        n_checks++;
        if (r.ce_cnt !== 0 || r.oe_cnt !== 0) begin
            n_fail++; $display("[TB] FAIL io_read_strobes: got ce=%0d oe=%0d expected 0/0", r.ce_cnt, r.oe_cnt);
        end
        last_read = 16'h00A5;
        run_access(1'b1, 1'b0, IO_ADDR, 16'h0F0F, 1, r);
        io_model = 16'h0F0F;
        n_checks++;
        if (bus.IO_out !== 16'h0F0F || r.done_cyc !== 1) begin
            n_fail++; $display("[TB] FAIL io_write: got io=%h done@%0d expected 0F0F done@1", bus.IO_out, r.done_cyc);
        end
        n_checks++;
        if (r.ce_cnt !== 0 || r.we_cnt !== 0 || bus.Data_to_CPU !== last_read) begin
            n_fail++; $display("[TB] FAIL io_write_side: got ce=%0d we=%0d data=%h expected 0/0/%h",
                               r.ce_cnt, r.we_cnt, bus.Data_to_CPU, last_read);
        end
    endtask

    task automatic test_held_strobe();
        result_t r;
        run_access(1'b0, 1'b1, 16'h0042, 16'h0, 10, r);
        n_checks++;
        if (r.done_cnt !== 1 || r.oe_cnt !== RD_WAIT || r.dv_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL held_single: got done=%0d oe=%0d dv=%0d expected 1/%0d/1",
                               r.done_cnt, r.oe_cnt, r.dv_cnt, RD_WAIT);
        end
        n_checks++;
        if (r.timeout || r.idle_cyc !== 11) begin
            n_fail++; $display("[TB] FAIL held_release: got idle@%0d expected idle@11", r.idle_cyc);
        end
        last_read = 16'hBEEF;
        run_access(1'b0, 1'b1, 16'h0010, 16'h0, 2, r);
        n_checks++;
        if (r.done_cnt !== 1 || r.dout !== 16'h1234) begin
            n_fail++; $display("[TB] FAIL held_second: got done=%0d data=%h expected 1/1234", r.done_cnt, r.dout);
        end
        last_read = 16'h1234;
    endtask

    task automatic test_both_strobes();
        result_t r;
        run_access(1'b1, 1'b1, 16'h0200, 16'h5AA5, 3, r);
        ref_mem[16'h0200] = 16'h5AA5;
        n_checks++;
        if (r.we_cnt !== WR_WAIT || r.oe_cnt !== 0 || r.dv_cnt !== 0) begin
            n_fail++; $display("[TB] FAIL both_is_write: got we=%0d oe=%0d dv=%0d expected %0d/0/0",
                               r.we_cnt, r.oe_cnt, r.dv_cnt, WR_WAIT);
        end
        n_checks++;
        if (bus.Data_to_CPU !== last_read) begin
            n_fail++; $display("[TB] FAIL both_keeps_data: got %h expected %h", bus.Data_to_CPU, last_read);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] dev;
        bit hit;
        hit = 1'b0;
        @(negedge Clk);
        bus.MAR     = 16'h0077;
        bus.MDR_out = ~ref_read(16'h0077);
        bus.Mem_WE  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (!bus.SRAM_WE_N) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("[TB] FAIL abort_reach_pulse: got no WE_N low expected WE_N low within 20 cycles");
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 || bus.SRAM_CE_N !== 1'b1 || bus.Busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL abort_immediate: got we_n=%b oe=%b ce_n=%b busy=%b expected 1/0/1/0",
                               bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.SRAM_CE_N, bus.Busy);
        end
        bus.Mem_WE = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        last_read = 16'h0;
        @(negedge Clk);
        dev = sram_wr.exists(16'h0077) ? sram_wr[16'h0077] : init_pat(16'h0077);
        n_checks++;
        if (dev !== ref_read(16'h0077) || bus.Busy !== 1'b0 || bus.Data_to_CPU !== 16'h0) begin
            n_fail++; $display("[TB] FAIL abort_no_write: got mem=%h busy=%b data=%h expected mem=%h busy=0 data=0",
                               dev, bus.Busy, bus.Data_to_CPU, ref_read(16'h0077));
        end
        io_model = 16'h0;
    endtask

    task automatic test_random();
        result_t     r;
        bit          wr, rd;
        logic [15:0] a, d, exp_data;
        int          ed, hold, exp_idle, exp_ce;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       begin wr = 1'b0; rd = 1'b1; end
                1:       begin wr = 1'b1; rd = 1'b0; end
                default: begin wr = 1'b1; rd = 1'b1; end
            endcase
            a = ($urandom_range(0, 4) == 0) ? IO_ADDR : (16'h0100 + 16'($urandom_range(0, 7)));
            d = 16'($urandom);
            bus.Switches = 16'($urandom);
            ed   = exp_done(wr, rd, a);
            hold = $urandom_range(1, ed + 4);
            exp_idle = (hold + 1 > ed + 2) ? hold + 1 : ed + 2;
            exp_ce   = (a == IO_ADDR) ? 0 : (wr ? WR_WAIT + 2 : RD_WAIT);
            exp_data = wr ? last_read : ((a == IO_ADDR) ? bus.Switches : ref_read(a));
            run_access(wr, rd, a, d, hold, r);
            if (wr) begin
                if (a == IO_ADDR) io_model = d;
                else              ref_mem[a] = d;
            end else begin
                last_read = exp_data;
            end
            n_checks++;
            if (r.timeout || r.done_cyc !== ed || r.idle_cyc !== exp_idle || r.done_cnt !== 1) begin
                n_fail++; $display("[TB] FAIL rnd_timing[%0d]: got done@%0d idle@%0d x%0d expected done@%0d idle@%0d x1",
                                   t, r.done_cyc, r.idle_cyc, r.done_cnt, ed, exp_idle);
            end
            n_checks++;
            if (r.ce_cnt !== exp_ce || r.bus_bad || r.dv_cnt !== (wr ? 0 : 1)) begin
                n_fail++; $display("[TB] FAIL rnd_bus[%0d]: got ce=%0d bus_bad=%0d dv=%0d expected ce=%0d bus_bad=0 dv=%0d",
                                   t, r.ce_cnt, r.bus_bad, r.dv_cnt, exp_ce, wr ? 0 : 1);
            end
            n_checks++;
            if (bus.Data_to_CPU !== exp_data || bus.IO_out !== io_model) begin
                n_fail++; $display("[TB] FAIL rnd_data[%0d]: got data=%h io=%h expected data=%h io=%h",
                                   t, bus.Data_to_CPU, bus.IO_out, exp_data, io_model);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        last_read   = 16'h0;
        io_model    = 16'h0;
        Reset       = 1'b0;
        bus.Mem_OE  = 1'b0;
        bus.Mem_WE  = 1'b0;
        bus.MAR     = 16'h0;
        bus.MDR_out = 16'h0;
        bus.Switches = 16'h0;
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_held_strobe();
        test_both_strobes();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
